// File: rtl/ysyx_22041752_mem_stage_if.sv
// Execute->memory->writeback handshake, load-data return and forwarding signals of the
// memory stage. The master modport is the memory stage itself, the slave modport is the
// surrounding pipeline (execute, writeback, data memory, decode).
// Optional macro MS_MISALIGN_CHK_EN adds the misalignment flags.
interface ysyx_22041752_mem_stage_if #(
    parameter int unsigned PC_WD   = 32,
    parameter int unsigned DATA_WD = 64
);
    localparam int unsigned ES_TO_MS_WD = 11 + DATA_WD + PC_WD;
    localparam int unsigned MS_TO_WS_WD = 6 + DATA_WD + PC_WD;
    localparam int unsigned FWD_WD      = 7 + DATA_WD;

    logic                   es_to_ms_valid;
    logic [ES_TO_MS_WD-1:0] es_to_ms_bus;
    logic                   ms_allowin;
    logic                   ws_allowin;
    logic                   ms_to_ws_valid;
    logic [MS_TO_WS_WD-1:0] ms_to_ws_bus;
    logic                   data_rvalid;
    logic [DATA_WD-1:0]     data_rdata;
    logic [FWD_WD-1:0]      ms_forward_bus;
`ifdef MS_MISALIGN_CHK_EN
    logic                   ms_misalign;
    logic                   ms_misalign_seen;
`endif

    modport master (
`ifdef MS_MISALIGN_CHK_EN
        output ms_misalign,
        output ms_misalign_seen,
`endif
        input  es_to_ms_valid,
        input  es_to_ms_bus,
        input  ws_allowin,
        input  data_rvalid,
        input  data_rdata,
        output ms_allowin,
        output ms_to_ws_valid,
        output ms_to_ws_bus,
        output ms_forward_bus
    );

    modport slave (
`ifdef MS_MISALIGN_CHK_EN
        input  ms_misalign,
        input  ms_misalign_seen,
`endif
        output es_to_ms_valid,
        output es_to_ms_bus,
        output ws_allowin,
        output data_rvalid,
        output data_rdata,
        input  ms_allowin,
        input  ms_to_ws_valid,
        input  ms_to_ws_bus,
        input  ms_forward_bus
    );
endinterface

// File: rtl/ysyx_22041752_mem_stage.sv
// Memory-access pipeline stage: latches the execute payload, waits for load data, extracts
// and extends the addressed bytes, buffers the load result while writeback stalls, and
// drives the forwarding bus toward decode.
// Optional macro MS_MISALIGN_CHK_EN adds ms_misalign and its sticky copy ms_misalign_seen.
module ysyx_22041752_mem_stage #(
    parameter int unsigned PC_WD   = 32,
    parameter int unsigned DATA_WD = 64
) (
    input logic                                clk,
    input logic                                reset,
    ysyx_22041752_mem_stage_if.master          bus
);
    localparam int unsigned ES_TO_MS_WD = 11 + DATA_WD + PC_WD;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e                 state_q, state_d;
    logic                   ms_valid_q;
    logic [ES_TO_MS_WD-1:0] es_bus_q;
    logic [DATA_WD-1:0]     ld_buf_q;
    logic                   ld_capture;

    logic                   res_sext, res_zext, mem_re, rf_we;
    logic [1:0]             mem_bytes;
    logic [4:0]             rd;
    logic [DATA_WD-1:0]     alu_result;
    logic [PC_WD-1:0]       pc;

    assign res_sext   = es_bus_q[ES_TO_MS_WD-1];
    assign res_zext   = es_bus_q[ES_TO_MS_WD-2];
    assign mem_bytes  = es_bus_q[ES_TO_MS_WD-3:ES_TO_MS_WD-4];
    assign mem_re     = es_bus_q[ES_TO_MS_WD-5];
    assign rf_we      = es_bus_q[ES_TO_MS_WD-6];
    assign rd         = es_bus_q[ES_TO_MS_WD-7:ES_TO_MS_WD-11];
    assign alu_result = es_bus_q[PC_WD+DATA_WD-1:PC_WD];
    assign pc         = es_bus_q[PC_WD-1:0];

    logic ms_ready_go, ms_allowin, accept, accept_load;

    assign ms_ready_go = !mem_re || (state_q == StWait && bus.data_rvalid) || state_q == StDone;
    assign ms_allowin  = !ms_valid_q || (ms_ready_go && bus.ws_allowin);
    assign accept      = bus.es_to_ms_valid && ms_allowin;
    assign accept_load = accept && bus.es_to_ms_bus[ES_TO_MS_WD-5];

    // Load-tracking FSM: leave WAIT/DONE once the load retires, re-entering WAIT if a new
    // load is accepted in that same cycle.
    always_comb begin
        state_d    = state_q;
        ld_capture = 1'b0;
        unique case (state_q)
            StIdle: if (accept_load) state_d = StWait;
            StWait: begin
                if (bus.data_rvalid) begin
                    if (bus.ws_allowin) begin
                        state_d = accept_load ? StWait : StIdle;
                    end else begin
                        state_d    = StDone;
                        ld_capture = 1'b1;
                    end
                end
            end
            StDone: if (bus.ws_allowin) state_d = accept_load ? StWait : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Pipeline valid, payload, load buffer and FSM state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ms_valid_q <= 1'b0;
            es_bus_q   <= '0;
            ld_buf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ms_allowin) ms_valid_q <= bus.es_to_ms_valid;
            if (accept)     es_bus_q   <= bus.es_to_ms_bus;
            if (ld_capture) ld_buf_q   <= bus.data_rdata;
        end
    end

    // In WAIT the returning data passes straight through; afterwards the buffer holds it.
    logic [DATA_WD-1:0] ld_raw, ld_shifted, ld_fmt, final_result;
    logic               sext_en;

    assign ld_raw     = (state_q == StWait) ? bus.data_rdata : ld_buf_q;
    assign ld_shifted = ld_raw >> {alu_result[2:0], 3'b000};
    assign sext_en    = res_sext && !res_zext;

    // Select 1/2/4/8 bytes and extend; bytes shifted in from beyond bit 63 are zero.
    always_comb begin
        ld_fmt = ld_shifted;
        unique case (mem_bytes)
            2'b00: ld_fmt = {{(DATA_WD-8){sext_en && ld_shifted[7]}}, ld_shifted[7:0]};
            2'b01: ld_fmt = {{(DATA_WD-16){sext_en && ld_shifted[15]}}, ld_shifted[15:0]};
            2'b10: ld_fmt = {{(DATA_WD-32){sext_en && ld_shifted[31]}}, ld_shifted[31:0]};
            default: ld_fmt = ld_shifted;
        endcase
    end

    assign final_result = mem_re ? ld_fmt : alu_result;

    assign bus.ms_allowin     = ms_allowin;
    assign bus.ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign bus.ms_to_ws_bus   = {rf_we, rd, final_result, pc};
    assign bus.ms_forward_bus = {ms_valid_q && mem_re && !ms_ready_go,
                                 ms_valid_q && rf_we, final_result, rd};

`ifdef MS_MISALIGN_CHK_EN
    logic [2:0] size_mask;
    logic       misalign_seen_q;

    always_comb begin
        size_mask = 3'd0;
        unique case (mem_bytes)
            2'b00: size_mask = 3'd0;
            2'b01: size_mask = 3'd1;
            2'b10: size_mask = 3'd3;
            default: size_mask = 3'd7;
        endcase
    end

    assign bus.ms_misalign = ms_valid_q && mem_re && ((alu_result[2:0] & size_mask) != 3'd0);

    // Sticky record of any misaligned access since reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               misalign_seen_q <= 1'b0;
        else if (bus.ms_misalign) misalign_seen_q <= 1'b1;
    end

    assign bus.ms_misalign_seen = misalign_seen_q;
`endif
endmodule

// File: tb/tb_ysyx_22041752_mem_stage.sv
// Self-checking bench for the memory stage: directed sequences, a load-format vector table
// and a randomized run against a transaction-level model of the stage.
module tb_ysyx_22041752_mem_stage;
    localparam int unsigned PC_WD   = 32;
    localparam int unsigned DATA_WD = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ysyx_22041752_mem_stage_if #(.PC_WD(PC_WD), .DATA_WD(DATA_WD)) bus_if ();

    ysyx_22041752_mem_stage #(.PC_WD(PC_WD), .DATA_WD(DATA_WD)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [106:0] mk_bus(input logic sext, input logic zext,
                                            input logic [1:0] bytes, input logic re,
                                            input logic we, input logic [4:0] rd,
                                            input logic [63:0] alu, input logic [31:0] pc);
        return {sext, zext, bytes, re, we, rd, alu, pc};
    endfunction

    // Byte-by-byte load extraction: byte i of the result is memory byte (off+i), or zero
    // once past the end of the doubleword.
    function automatic logic [63:0] ld_ref(input logic [63:0] data, input int off,
                                           input int code, input logic sext);
        logic [63:0] r;
        int n;
        r = '0;
        n = 1 << code;
        for (int i = 0; i < n; i++)
            if (off + i < 8) r[i*8 +: 8] = data[(off+i)*8 +: 8];
        if (sext && n < 8 && r[n*8-1])
            for (int b = n * 8; b < 64; b++) r[b] = 1'b1;
        return r;
    endfunction

    task automatic drive(input logic ev, input logic [106:0] b, input logic wa,
                         input logic rv, input logic [63:0] rdata);
        @(negedge clk);
        bus_if.es_to_ms_valid = ev;
        bus_if.es_to_ms_bus   = b;
        bus_if.ws_allowin     = wa;
        bus_if.data_rvalid    = rv;
        bus_if.data_rdata     = rdata;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b1, 1'b0, '0);
    endtask

    function automatic logic [63:0] res_of();
        return bus_if.ms_to_ws_bus[95:32];
    endfunction

    typedef struct {
        logic [2:0]  off;
        int          code;
        logic        sext;
        logic [63:0] data;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[11];

    // Randomized-run model state: at most one instruction resident in the stage.
    logic        m_held, m_load, m_have, m_we, m_sext;
    logic [63:0] m_data, m_alu;
    logic [4:0]  m_rd;
    logic [31:0] m_pc;
    int          m_code;

    initial begin
        reset = 1'b0;
        bus_if.es_to_ms_valid = 1'b0;
        bus_if.es_to_ms_bus   = '0;
        bus_if.ws_allowin     = 1'b1;
        bus_if.data_rvalid    = 1'b0;
        bus_if.data_rdata     = '0;

        vecs[0]  = '{3'd3, 0, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1]  = '{3'd0, 0, 1'b0, 64'h1122_3344_5566_7788, 64'h0000_0000_0000_0088};
        vecs[2]  = '{3'd0, 0, 1'b1, 64'h1122_3344_5566_7788, 64'hFFFF_FFFF_FFFF_FF88};
        vecs[3]  = '{3'd2, 1, 1'b1, 64'h1122_3344_5566_7788, 64'h0000_0000_0000_5566};
        vecs[4]  = '{3'd6, 1, 1'b0, 64'h1122_3344_5566_7788, 64'h0000_0000_0000_1122};
        vecs[5]  = '{3'd4, 2, 1'b1, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001};
        vecs[6]  = '{3'd4, 2, 1'b0, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF};
        vecs[7]  = '{3'd0, 3, 1'b0, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788};
        vecs[8]  = '{3'd4, 3, 1'b0, 64'h1122_3344_5566_7788, 64'h0000_0000_1122_3344};
        vecs[9]  = '{3'd6, 2, 1'b1, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_8000};
        vecs[10] = '{3'd7, 1, 1'b1, 64'hFF00_0000_0000_0000, 64'h0000_0000_0000_00FF};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_allowin", 128'(bus_if.ms_allowin), 128'd1);
        chk("rst_valid", 128'(bus_if.ms_to_ws_valid), 128'd0);
        chk("rst_ws_bus", 128'(bus_if.ms_to_ws_bus), 128'd0);
        chk("rst_fwd", 128'(bus_if.ms_forward_bus), 128'd0);
        @(negedge clk);
        reset = 1'b1;

        // Non-load passes through in one cycle.
        drive(1'b1, mk_bus(0, 0, 2'd0, 0, 1, 5'd5, 64'h1234, 32'h8000_0000), 1'b1, 1'b0, '0);
        chk("alu_accept_allowin", 128'(bus_if.ms_allowin), 128'd1);
        idle();
        chk("alu_valid", 128'(bus_if.ms_to_ws_valid), 128'd1);
        chk("alu_result", 128'(res_of()), 128'h1234);
        chk("alu_ws_rd", 128'(bus_if.ms_to_ws_bus[100:96]), 128'd5);
        chk("alu_fwd_valid", 128'(bus_if.ms_forward_bus[69]), 128'd1);
        chk("alu_ld_block", 128'(bus_if.ms_forward_bus[70]), 128'd0);
        chk("alu_fwd_data", 128'(bus_if.ms_forward_bus[68:5]), 128'h1234);
        idle();
        chk("alu_drained", 128'(bus_if.ms_to_ws_valid), 128'd0);

        // lb with two wait cycles before data returns.
        drive(1'b1, mk_bus(1, 0, 2'd0, 1, 1, 5'd7, 64'h1003, 32'h8000_0004), 1'b1, 1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            idle();
            chk("lb_wait_block", 128'(bus_if.ms_forward_bus[70]), 128'd1);
            chk("lb_wait_valid", 128'(bus_if.ms_to_ws_valid), 128'd0);
            chk("lb_wait_allowin", 128'(bus_if.ms_allowin), 128'd0);
        end
        drive(1'b0, '0, 1'b1, 1'b1, 64'h0000_0000_8000_0000);
        chk("lb_valid", 128'(bus_if.ms_to_ws_valid), 128'd1);
        chk("lb_result", 128'(res_of()), 128'hFFFF_FFFF_FFFF_FF80);
        chk("lb_block_clear", 128'(bus_if.ms_forward_bus[70]), 128'd0);
        idle();
        chk("lb_drained", 128'(bus_if.ms_to_ws_valid), 128'd0);

        // lwu returning while writeback stalls: result held from the buffer.
        drive(1'b1, mk_bus(0, 1, 2'd2, 1, 1, 5'd9, 64'h2004, 32'h8000_0008), 1'b1, 1'b0, '0);
        drive(1'b0, '0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0000);
        chk("lwu_rv_valid", 128'(bus_if.ms_to_ws_valid), 128'd1);
        chk("lwu_rv_allowin", 128'(bus_if.ms_allowin), 128'd0);
        chk("lwu_rv_result", 128'(res_of()), 128'hDEAD_BEEF);
        drive(1'b0, '0, 1'b0, 1'b0, 64'h5555_5555_5555_5555);
        chk("lwu_held_valid", 128'(bus_if.ms_to_ws_valid), 128'd1);
        chk("lwu_held_result", 128'(res_of()), 128'hDEAD_BEEF);
        chk("lwu_held_block", 128'(bus_if.ms_forward_bus[70]), 128'd0);
        drive(1'b0, '0, 1'b1, 1'b1, 64'h5555_5555_5555_5555);
        chk("lwu_release_allowin", 128'(bus_if.ms_allowin), 128'd1);
        chk("lwu_release_result", 128'(res_of()), 128'hDEAD_BEEF);
        idle();
        chk("lwu_drained", 128'(bus_if.ms_to_ws_valid), 128'd0);

        // ld retires while an add is accepted the same cycle: no bubble.
        drive(1'b1, mk_bus(0, 0, 2'd3, 1, 1, 5'd2, 64'h100, 32'h8000_000C), 1'b1, 1'b0, '0);
        drive(1'b1, mk_bus(0, 0, 2'd0, 0, 1, 5'd3, 64'h42, 32'h8000_0010), 1'b1, 1'b1,
              64'hCAFE_F00D_1234_5678);
        chk("ldadd_allowin", 128'(bus_if.ms_allowin), 128'd1);
        chk("ldadd_ld_result", 128'(res_of()), 128'hCAFE_F00D_1234_5678);
        idle();
        chk("ldadd_add_valid", 128'(bus_if.ms_to_ws_valid), 128'd1);
        chk("ldadd_add_result", 128'(res_of()), 128'h42);
        chk("ldadd_add_pc", 128'(bus_if.ms_to_ws_bus[31:0]), 128'h8000_0010);
        idle();

        // Reset during WAIT drops the load; a later rvalid is ignored.
        drive(1'b1, mk_bus(1, 0, 2'd2, 1, 1, 5'd4, 64'h3000, 32'h8000_0014), 1'b1, 1'b0, '0);
        idle();
        chk("rstw_block_before", 128'(bus_if.ms_forward_bus[70]), 128'd1);
        reset = 1'b0;
        #1;
        chk("rstw_allowin", 128'(bus_if.ms_allowin), 128'd1);
        chk("rstw_valid", 128'(bus_if.ms_to_ws_valid), 128'd0);
        chk("rstw_ws_bus", 128'(bus_if.ms_to_ws_bus), 128'd0);
        chk("rstw_fwd", 128'(bus_if.ms_forward_bus), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rstw_rv_valid", 128'(bus_if.ms_to_ws_valid), 128'd0);
        chk("rstw_rv_fwd", 128'(bus_if.ms_forward_bus), 128'd0);
        idle();
        chk("rstw_after_valid", 128'(bus_if.ms_to_ws_valid), 128'd0);
        chk("rstw_after_allowin", 128'(bus_if.ms_allowin), 128'd1);

`ifdef MS_MISALIGN_CHK_EN
        drive(1'b1, mk_bus(1, 0, 2'd1, 1, 1, 5'd6, 64'h4001, 32'h8000_0018), 1'b1, 1'b0, '0);
        idle();
        chk("mis_lh1", 128'(bus_if.ms_misalign), 128'd1);
        drive(1'b0, '0, 1'b1, 1'b1, 64'h0);
        idle();
        chk("mis_seen", 128'(bus_if.ms_misalign_seen), 128'd1);
        drive(1'b1, mk_bus(1, 0, 2'd1, 1, 1, 5'd6, 64'h4002, 32'h8000_001C), 1'b1, 1'b0, '0);
        idle();
        chk("mis_lh2", 128'(bus_if.ms_misalign), 128'd0);
        chk("mis_seen_sticky", 128'(bus_if.ms_misalign_seen), 128'd1);
        drive(1'b0, '0, 1'b1, 1'b1, 64'h0);
        idle();
`endif

        // Load formatting vectors.
        for (int v = 0; v < 11; v++) begin
            logic zx;
            zx = !vecs[v].sext && vecs[v].code != 3;
            drive(1'b1, mk_bus(vecs[v].sext, zx, 2'(vecs[v].code), 1, 1, 5'd10,
                               {61'h100, vecs[v].off}, 32'h9000_0000), 1'b1, 1'b0, '0);
            drive(1'b0, '0, 1'b1, 1'b1, vecs[v].data);
            chk($sformatf("vec%0d_valid", v), 128'(bus_if.ms_to_ws_valid), 128'd1);
            chk($sformatf("vec%0d_result", v), 128'(res_of()), 128'(vecs[v].exp));
            idle();
        end

        // Randomized traffic against the model.
        m_held = 1'b0; m_load = 1'b0; m_have = 1'b0; m_we = 1'b0; m_sext = 1'b0;
        m_data = '0; m_alu = '0; m_rd = '0; m_pc = '0; m_code = 0;
        for (int c = 0; c < 400; c++) begin
            logic        ev, wa, rv, we, re, sx, pending, rv_eff, ready, allow;
            logic [4:0]  rd;
            logic [63:0] alu, rdata, res;
            logic [31:0] pc;
            int          code;
            ev    = ($urandom % 2) == 0;
            wa    = ($urandom % 4) != 0;
            we    = ($urandom % 4) != 0;
            re    = ($urandom % 2) == 0;
            sx    = ($urandom % 2) == 0;
            code  = $urandom_range(0, 3);
            rd    = 5'($urandom);
            alu   = {$urandom, $urandom};
            pc    = $urandom;
            rdata = {$urandom, $urandom};
            pending = m_held && m_load && !m_have;
            rv = pending ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
            drive(ev, mk_bus(re && sx, re && !sx && code != 3, 2'(code), re, we, rd, alu, pc),
                  wa, rv, rdata);

            rv_eff = rv && pending;
            ready  = !m_load || m_have || rv_eff;
            allow  = !m_held || (ready && wa);
            chk("rnd_allowin", 128'(bus_if.ms_allowin), 128'(allow));
            chk("rnd_valid", 128'(bus_if.ms_to_ws_valid), 128'(m_held && ready));
            chk("rnd_fwd_valid", 128'(bus_if.ms_forward_bus[69]), 128'(m_held && m_we));
            chk("rnd_ld_block", 128'(bus_if.ms_forward_bus[70]),
                128'(m_held && m_load && !ready));
            if (m_held && ready) begin
                res = m_load ? ld_ref(m_have ? m_data : rdata, int'(m_alu[2:0]), m_code, m_sext)
                             : m_alu;
                chk("rnd_ws_bus", 128'(bus_if.ms_to_ws_bus), 128'({m_we, m_rd, res, m_pc}));
            end

            if (allow) begin
                m_held = ev;
                m_load = re; m_we = we; m_sext = re && sx; m_code = code;
                m_rd = rd; m_alu = alu; m_pc = pc; m_have = 1'b0;
            end else if (rv_eff) begin
                m_have = 1'b1;
                m_data = rdata;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
